// File: rtl/data_sampler_mv.sv
// ---------------------------------------------------------------------------
// data_sampler_mv
// Majority-vote data sampler for an oversampling UART receiver. NSAMP samples
// are taken around the middle of each bit period. One cycle after the last
// oversample edge of the bit, the voted value is presented with a one-cycle
// valid strobe.
//
// Optional feature: define DATA_SAMPLER_NOISE_DETECT_EN to make noise_err
// flag bits whose samples were not unanimous. When the macro is undefined,
// noise_err is tied to 0.
//
// Parameters
//   PRESCALE_W  width of edge_cnt / prescale
//   NSAMP       samples per bit (odd, 3..7)
//   CNT_W       vote counter width (>= clog2(NSAMP+1))
// Ports
//   CLK          clock, rising edge
//   RST          asynchronous reset, active low
//   samp_en      sampling enable from the RX FSM
//   rx_in        synchronised serial line
//   edge_cnt     oversample edge index within the bit (0..prescale-1)
//   prescale     oversampling ratio (even, >= 2*NSAMP)
//   sampled_bit  majority-voted bit, held between decisions
//   bit_valid    one-cycle strobe, asserted when sampled_bit is updated
//   noise_err    last decided bit had non-unanimous samples
// ---------------------------------------------------------------------------
module data_sampler_mv #(
    parameter int PRESCALE_W = 6,
    parameter int NSAMP      = 3,
    parameter int CNT_W      = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  samp_en,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sampled_bit,
    output logic                  bit_valid,
    output logic                  noise_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WAIT    = 2'd2
    } state_t;

    localparam logic [PRESCALE_W-1:0] HALF_SAMP  = PRESCALE_W'(NSAMP / 2);
    localparam logic [PRESCALE_W-1:0] LAST_OFS   = PRESCALE_W'(NSAMP - 1);
    localparam logic [CNT_W-1:0]      MAJ_THRESH = CNT_W'(NSAMP / 2);
    localparam logic [CNT_W-1:0]      SAMP_LAST  = CNT_W'(NSAMP - 1);
    localparam logic [CNT_W-1:0]      SAMP_ALL   = CNT_W'(NSAMP);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] samp_cnt_q, samp_cnt_d;
    logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;
    logic             sampled_bit_q, sampled_bit_d;
    logic             bit_valid_q, bit_valid_d;

    logic [PRESCALE_W-1:0] win_start;
    logic [PRESCALE_W-1:0] win_last;
    logic [PRESCALE_W-1:0] bit_last;
    logic                  in_window;
    logic                  at_win_last;
    logic                  at_bit_end;

    // The sampling window is centred on the middle of the bit period.
    assign win_start   = (prescale >> 1) - HALF_SAMP;
    assign win_last    = win_start + LAST_OFS;
    assign bit_last    = prescale - PRESCALE_W'(1);
    assign in_window   = (edge_cnt >= win_start) && (edge_cnt <= win_last);
    assign at_win_last = (edge_cnt == win_last);
    assign at_bit_end  = (edge_cnt == bit_last);

    always_comb begin
        state_d       = state_q;
        samp_cnt_d    = samp_cnt_q;
        ones_cnt_d    = ones_cnt_q;
        sampled_bit_d = sampled_bit_q;
        bit_valid_d   = 1'b0;

        if (!samp_en) begin
            state_d    = IDLE;
            samp_cnt_d = '0;
            ones_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = COLLECT;
                    samp_cnt_d = '0;
                    ones_cnt_d = '0;
                end
                COLLECT: begin
                    if (at_bit_end) begin
                        // Bit ended with an incomplete window: drop partial votes.
                        samp_cnt_d = '0;
                        ones_cnt_d = '0;
                    end else if (in_window) begin
                        samp_cnt_d = samp_cnt_q + CNT_W'(1);
                        ones_cnt_d = ones_cnt_q + CNT_W'(rx_in);
                        // Only a window seen from its first sample may be decided;
                        // a window joined part-way is discarded at bit end.
                        if (at_win_last && (samp_cnt_q == SAMP_LAST)) begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (at_bit_end) begin
                        sampled_bit_d = (ones_cnt_q > MAJ_THRESH);
                        bit_valid_d   = 1'b1;
                        samp_cnt_d    = '0;
                        ones_cnt_d    = '0;
                        state_d       = COLLECT;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    samp_cnt_d = '0;
                    ones_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            samp_cnt_q    <= '0;
            ones_cnt_q    <= '0;
            sampled_bit_q <= 1'b0;
            bit_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            samp_cnt_q    <= samp_cnt_d;
            ones_cnt_q    <= ones_cnt_d;
            sampled_bit_q <= sampled_bit_d;
            bit_valid_q   <= bit_valid_d;
        end
    end

    assign sampled_bit = sampled_bit_q;
    assign bit_valid   = bit_valid_q;

`ifdef DATA_SAMPLER_NOISE_DETECT_EN
    logic noise_err_q, noise_err_d;

    // Noise flag is refreshed only on a decision and held otherwise.
    always_comb begin
        noise_err_d = noise_err_q;
        if (bit_valid_d) begin
            noise_err_d = (ones_cnt_q != '0) && (ones_cnt_q != SAMP_ALL);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            noise_err_q <= 1'b0;
        end else begin
            noise_err_q <= noise_err_d;
        end
    end

    assign noise_err = noise_err_q;
`else
    assign noise_err = 1'b0;
`endif

endmodule

// File: doc/data_sampler_mv.md
DATA_SAMPLER_MV -- requirements
Module: data_sampler_mv

Interface
REQ-001 Parameter PRESCALE_W, default 6: width of edge_cnt and prescale.
REQ-002 Parameter NSAMP, default 3: samples per bit, odd, legal range 3..7.
REQ-003 Parameter CNT_W, default 3: vote-counter width, >= clog2(NSAMP+1).
REQ-004 Port CLK  input  1  clock; all flops on rising edge.
REQ-005 Port RST  input  1  reset, asynchronous, active-low.
REQ-006 Port samp_en  input  1  sampling enable from RX FSM.
REQ-007 Port rx_in  input  1  serial line, already synchronised.
REQ-008 Port edge_cnt  input  PRESCALE_W  oversample edge index within the bit, 0..prescale-1.
REQ-009 Port prescale  input  PRESCALE_W  oversampling ratio, even, >= 2*NSAMP; quasi-static while samp_en=1.
REQ-010 Port sampled_bit  output  1  majority-voted bit value.
REQ-011 Port bit_valid  output  1  one-cycle strobe, sampled_bit updated.
REQ-012 Port noise_err  output  1  samples of last bit not unanimous (see Configuration).

Function
REQ-013 Window start S = prescale/2 - NSAMP/2 (integer division); sample k (k = 0..NSAMP-1) SHALL be taken in the cycle where samp_en=1 and edge_cnt == S+k.
REQ-014 Each sample SHALL increment the sample counter (samp_cnt); if rx_in=1 it SHALL also increment the ones counter (ones_cnt). Both counters are CNT_W bits.
REQ-015 FSM states SHALL be IDLE, COLLECT and WAIT, encoded in 2 bits.
REQ-016 IDLE->COLLECT SHALL occur on samp_en=1, with both counters cleared.
REQ-017 COLLECT->WAIT SHALL occur in the cycle sample NSAMP-1 is taken.
REQ-018 In WAIT, when edge_cnt == prescale-1, the block SHALL load sampled_bit = (ones_cnt > NSAMP/2), pulse bit_valid for exactly 1 cycle, clear the counters and go to COLLECT.
REQ-019 Decision latency SHALL be 1 cycle: outputs register on the edge that samples edge_cnt == prescale-1.
REQ-020 If edge_cnt == prescale-1 occurs in COLLECT (incomplete window), the block SHALL discard the partial votes, clear the counters, not pulse bit_valid and stay in COLLECT.
REQ-021 samp_en=0 in any state SHALL force IDLE next cycle, clear the counters and suppress bit_valid, including in the decision cycle.
REQ-022 sampled_bit SHALL hold its value between decisions and SHALL NOT be cleared by samp_en=0.
REQ-023 edge_cnt values outside the window and outside prescale-1 SHALL NOT change state.

Reset
REQ-024 On RST=0, state SHALL be IDLE, the counters 0, sampled_bit 0, bit_valid 0 and noise_err 0, immediately and independent of CLK.
REQ-025 Reset asserted mid-bit SHALL discard all votes; after release the first bit_valid SHALL require a complete new window.

Configuration
REQ-026 Macro DATA_SAMPLER_NOISE_DETECT_EN defined: noise_err SHALL load (ones_cnt != 0 && ones_cnt != NSAMP) on each bit_valid cycle and hold its value until the next bit_valid or reset.
REQ-027 Macro DATA_SAMPLER_NOISE_DETECT_EN undefined: the noise_err port SHALL remain and be tied to 0, and no noise logic SHALL be synthesised.

Verification
REQ-028 NSAMP=3, prescale=8, rx_in=1 at edge_cnt 3,4,5 -> at edge_cnt 7: sampled_bit=1, bit_valid high 1 cycle, noise_err=0.
REQ-029 NSAMP=3, prescale=8, rx_in=0,1,0 at edge_cnt 3,4,5 -> sampled_bit=0, bit_valid=1, noise_err=1 (macro on) or 0 (macro off).
REQ-030 NSAMP=5, prescale=16, rx_in=1,1,0,0,1 at edge_cnt 6..10 -> sampled_bit=1 at edge_cnt 15.
REQ-031 samp_en dropped at edge_cnt 4, then restored at edge_cnt 0 of the next bit -> no bit_valid for the aborted bit, and a correct decision for the next bit.
REQ-032 RST pulsed low at edge_cnt 4 while sampled_bit=1 -> all outputs 0 at once, and no bit_valid until a full window completes.
REQ-033 10 back-to-back bits of pattern 0x2D5 -> 10 bit_valid pulses, each prescale cycles apart, reproducing the pattern LSB first.
